// File: rtl/cnn_pkg.sv
// Shared types and constants for the conv1 -> pool1 datapath.
package cnn_pkg;

   localparam int MAP_W_DEF    = 24;   // conv1 feature-map width/height
   localparam int DATA_W_DEF   = 16;   // signed pixel width
   localparam int RD_ADDR_W    = 10;   // conv1 memory address width
   localparam int POOL_ADDR_W  = 8;    // pooled-map index width
   localparam int FETCH_PHASES = 4;    // reads per 2x2 window

   // Number of pooled outputs produced from a square map of width map_w.
   function automatic int pooled_size(input int map_w);
      return (map_w / 2) * (map_w / 2);
   endfunction

   localparam int POOL_MAP_SIZE = pooled_size(MAP_W_DEF);   // 144

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DRAIN,
      ST_OUT,
      ST_DONE
   } pool_state_t;

endpackage

// File: rtl/pool1_addr_gen.sv
// Maps a pooling window (r, c) and fetch phase to a conv1 memory address.
// Phase order: top-left, top-right, bottom-left, bottom-right.
module pool1_addr_gen
   import cnn_pkg::*;
#(
   parameter int MAP_W = MAP_W_DEF
) (
   input  logic [POOL_ADDR_W-1:0] r,
   input  logic [POOL_ADDR_W-1:0] c,
   input  logic [1:0]             phase,
   output logic [RD_ADDR_W-1:0]   rd_addr
);

   logic [RD_ADDR_W-1:0] offset [FETCH_PHASES];
   logic [RD_ADDR_W-1:0] base;

   // Per-phase offset from the window base: bit 1 selects the row below, bit 0 the next column.
   generate
      for (genvar gi = 0; gi < FETCH_PHASES; gi++) begin : g_offset
         assign offset[gi] = RD_ADDR_W'(((gi / 2) * MAP_W) + (gi % 2));
      end
   endgenerate

   // Top-left pixel of the window: row 2r, column 2c.
   assign base    = (RD_ADDR_W'(r) * RD_ADDR_W'(2 * MAP_W)) + (RD_ADDR_W'(c) << 1);
   assign rd_addr = base + offset[phase];

endmodule

// File: rtl/pool1_mem_read.sv
// 2x2 max-pool reader: walks the conv1 map in raster window order, reads the
// four pixels of each window, and hands the signed maximum downstream with a
// valid/ready handshake.
module pool1_mem_read
   import cnn_pkg::*;
#(
   parameter int MAP_W  = MAP_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic signed [DATA_W-1:0] rd_data,
   input  logic                     pool_ready,
   output logic [RD_ADDR_W-1:0]     rd_addr,
   output logic                     rd_en,
   output logic signed [DATA_W-1:0] pool_data,
   output logic [POOL_ADDR_W-1:0]   pool_addr,
   output logic                     pool_valid,
   output logic                     done
);

   localparam int                     HALF_W  = MAP_W / 2;
   localparam logic [POOL_ADDR_W-1:0] LAST_RC = POOL_ADDR_W'(HALF_W - 1);

   pool_state_t              state_reg;
   logic [POOL_ADDR_W-1:0]   r_reg;
   logic [POOL_ADDR_W-1:0]   c_reg;
   logic [1:0]               phase_reg;
   logic                     rd_en_reg;
   logic                     ret_valid_reg;   // rd_data carries a pixel this cycle
   logic [1:0]               ret_phase_reg;   // which phase that pixel belongs to
   logic signed [DATA_W-1:0] max_reg;
   logic signed [DATA_W-1:0] max_next;
   logic signed [DATA_W-1:0] pool_data_reg;
   logic [POOL_ADDR_W-1:0]   pool_addr_reg;
   logic                     pool_valid_reg;
   logic                     done_reg;
   logic [POOL_ADDR_W-1:0]   win_index;
   logic                     last_win;

   pool1_addr_gen #(
      .MAP_W (MAP_W)
   ) u_addr_gen (
      .r       (r_reg),
      .c       (c_reg),
      .phase   (phase_reg),
      .rd_addr (rd_addr)
   );

   assign win_index = (r_reg * POOL_ADDR_W'(HALF_W)) + c_reg;
   assign last_win  = (r_reg == LAST_RC) && (c_reg == LAST_RC);

   // Running maximum: the first pixel of a window replaces the held value,
   // later pixels win only when strictly greater (ties keep the held value).
   always_comb begin
      max_next = max_reg;
      if (ret_valid_reg) begin
         if (ret_phase_reg == 2'd0) begin
            max_next = rd_data;
         end else if (rd_data > max_reg) begin
            max_next = rd_data;
         end
      end
   end

   // Window sequencer with registered outputs; read returns are tracked one cycle behind the strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         r_reg          <= '0;
         c_reg          <= '0;
         phase_reg      <= '0;
         rd_en_reg      <= 1'b0;
         ret_valid_reg  <= 1'b0;
         ret_phase_reg  <= '0;
         max_reg        <= '0;
         pool_data_reg  <= '0;
         pool_addr_reg  <= '0;
         pool_valid_reg <= 1'b0;
         done_reg       <= 1'b0;
      end else begin
         ret_valid_reg <= rd_en_reg;
         ret_phase_reg <= phase_reg;
         max_reg       <= max_next;
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  state_reg <= ST_FETCH;
                  r_reg     <= '0;
                  c_reg     <= '0;
                  phase_reg <= '0;
                  rd_en_reg <= 1'b1;
               end
            end
            ST_FETCH: begin
               if (phase_reg == 2'd3) begin
                  state_reg <= ST_DRAIN;
                  phase_reg <= '0;
                  rd_en_reg <= 1'b0;
               end else begin
                  phase_reg <= phase_reg + 2'd1;
               end
            end
            ST_DRAIN: begin
               // max_next already includes the bottom-right pixel arriving now.
               state_reg      <= ST_OUT;
               pool_data_reg  <= max_next;
               pool_addr_reg  <= win_index;
               pool_valid_reg <= 1'b1;
            end
            ST_OUT: begin
               if (pool_ready) begin
                  pool_valid_reg <= 1'b0;
                  if (last_win) begin
                     state_reg <= ST_DONE;
                     done_reg  <= 1'b1;
                  end else begin
                     state_reg <= ST_FETCH;
                     rd_en_reg <= 1'b1;
                     if (c_reg == LAST_RC) begin
                        c_reg <= '0;
                        r_reg <= r_reg + POOL_ADDR_W'(1);
                     end else begin
                        c_reg <= c_reg + POOL_ADDR_W'(1);
                     end
                  end
               end
            end
            ST_DONE: begin
               if (start) begin
                  state_reg <= ST_FETCH;
                  done_reg  <= 1'b0;
                  r_reg     <= '0;
                  c_reg     <= '0;
                  phase_reg <= '0;
                  rd_en_reg <= 1'b1;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign rd_en      = rd_en_reg;
   assign pool_data  = pool_data_reg;
   assign pool_addr  = pool_addr_reg;
   assign pool_valid = pool_valid_reg;
   assign done       = done_reg;

endmodule

// File: tb/tb_pool1_mem_read.sv
// Scoreboard bench for pool1_mem_read: a conv1 memory model answers reads,
// expected reads and pooled results are queued at start, and a monitor
// compares every read strobe and every transfer against those queues.
module tb_pool1_mem_read;

   localparam int MAP_W  = 24;
   localparam int DATA_W = 16;
   localparam int HALF   = MAP_W / 2;
   localparam int NWIN   = HALF * HALF;
   localparam int MSIZE  = MAP_W * MAP_W;

   logic                     clk        = 1'b0;
   logic                     reset      = 1'b1;
   logic                     start      = 1'b0;
   logic                     pool_ready = 1'b0;
   logic signed [DATA_W-1:0] rd_data    = '0;
   logic [9:0]               rd_addr;
   logic                     rd_en;
   logic signed [DATA_W-1:0] pool_data;
   logic [7:0]               pool_addr;
   logic                     pool_valid;
   logic                     done;

   pool1_mem_read #(.MAP_W(MAP_W), .DATA_W(DATA_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .rd_data    (rd_data),
      .pool_ready (pool_ready),
      .rd_addr    (rd_addr),
      .rd_en      (rd_en),
      .pool_data  (pool_data),
      .pool_addr  (pool_addr),
      .pool_valid (pool_valid),
      .done       (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // conv1 memory: data appears one cycle after the strobe
   logic signed [DATA_W-1:0] mem [MSIZE];
   always @(posedge clk) begin
      if (rd_en && (rd_addr < 10'(MSIZE))) rd_data <= mem[rd_addr];
   end

   typedef struct {
      int data;
      int addr;
   } pool_exp_t;

   pool_exp_t exp_q[$];
   int        addr_q[$];
   int        errors = 0;
   int        checks = 0;
   int        ready_mode = 1;   // 0 = low, 1 = high, 2 = random
   int        xfer_count = 0;
   int        first_valid_cyc = -1;
   int        last_xfer_cyc = -1;
   int        last_pool_addr = -1;
   int        start_cyc = 0;

   task automatic chk(input string name, input logic signed [31:0] got, input logic signed [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // Reference: each window's result is the signed max of its four pixels.
   task automatic load_expected();
      for (int r = 0; r < HALF; r++) begin
         for (int c = 0; c < HALF; c++) begin
            int base;
            int m;
            int a [4];
            pool_exp_t e;
            base = 2 * r * MAP_W + 2 * c;
            a[0] = base;
            a[1] = base + 1;
            a[2] = base + MAP_W;
            a[3] = base + MAP_W + 1;
            m = mem[a[0]];
            for (int k = 0; k < 4; k++) begin
               addr_q.push_back(a[k]);
               if (int'(mem[a[k]]) > m) m = mem[a[k]];
            end
            e.data = m;
            e.addr = r * HALF + c;
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic issue_start(input bit push);
      @(posedge clk);
      #1;
      if (push) begin
         load_expected();
         first_valid_cyc = -1;
         last_xfer_cyc   = -1;
         last_pool_addr  = -1;
         xfer_count      = 0;
      end
      start     = 1'b1;
      start_cyc = cyc;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(output int dcyc);
      int n;
      n = 0;
      @(negedge clk);
      while (!done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL wait_done: done=%0b after %0d cycles, expected 1", done, n);
      end
      dcyc = cyc;
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      @(negedge clk);
      while (!pool_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("wait_valid", pool_valid, 1);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_rd_addr"}, rd_addr, 0);
      chk({tag, "_rd_en"}, rd_en, 0);
      chk({tag, "_pool_data"}, pool_data, 0);
      chk({tag, "_pool_addr"}, pool_addr, 0);
      chk({tag, "_pool_valid"}, pool_valid, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   // downstream ready driver
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       pool_ready = 1'b0;
            1:       pool_ready = 1'b1;
            default: pool_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // monitor: every read and every transfer is matched against the queues
   always @(negedge clk) begin
      if (!reset) begin
         if (rd_en) begin
            if (addr_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_read: rd_addr=%0d with no read expected", rd_addr);
            end else begin
               int a;
               a = addr_q.pop_front();
               chk("rd_addr", rd_addr, a);
            end
         end
         if (pool_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (pool_valid && pool_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: pool_addr=%0d pool_data=%0d with none expected", pool_addr, pool_data);
            end else begin
               pool_exp_t e;
               e = exp_q.pop_front();
               chk("pool_data", pool_data, e.data);
               chk("pool_addr", pool_addr, e.addr);
               $display("xfer %0d: pool_addr=%0d pool_data=%0d (exp %0d/%0d)", xfer_count, pool_addr, pool_data, e.addr, e.data);
            end
            xfer_count++;
            last_xfer_cyc  = cyc;
            last_pool_addr = pool_addr;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int dcyc;
      int n;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      @(posedge clk);
      #1 reset = 1'b0;

      // map 1: value = address, ready always high, cycle-exact timing
      for (int i = 0; i < MSIZE; i++) mem[i] = DATA_W'(i);
      ready_mode = 1;
      issue_start(1);
      wait_done(dcyc);
      chk("first_latency", first_valid_cyc - start_cyc, 6);
      chk("last_xfer_cycles", last_xfer_cyc - start_cyc, 864);
      chk("done_after_last", dcyc - last_xfer_cyc, 1);
      chk("xfer_count_1", xfer_count, NWIN);
      chk("last_pool_addr_1", last_pool_addr, NWIN - 1);
      repeat (5) @(negedge clk);
      chk("done_hold", done, 1);
      chk("done_pool_valid", pool_valid, 0);
      chk("done_rd_en", rd_en, 0);

      // map 2: negative data, restart from DONE, random ready
      for (int i = 0; i < MSIZE; i++) mem[i] = DATA_W'(-i - 1);
      ready_mode = 2;
      issue_start(1);
      @(negedge clk);
      chk("restart_done", done, 0);
      chk("restart_rd_en", rd_en, 1);
      chk("restart_rd_addr", rd_addr, 0);
      wait_done(dcyc);
      chk("xfer_count_2", xfer_count, NWIN);
      chk("last_pool_addr_2", last_pool_addr, NWIN - 1);

      // map 3: random data, stall in OUT, ignored starts in FETCH and OUT
      for (int i = 0; i < MSIZE; i++) mem[i] = DATA_W'($urandom);
      ready_mode = 0;
      issue_start(1);
      wait_valid();
      for (int i = 0; i < 10; i++) begin
         chk("stall_valid", pool_valid, 1);
         chk("stall_rd_en", rd_en, 0);
         if (exp_q.size() > 0) begin
            chk("stall_data", pool_data, exp_q[0].data);
            chk("stall_addr", pool_addr, exp_q[0].addr);
         end
         @(negedge clk);
      end
      ready_mode = 1;
      @(negedge clk);
      @(negedge clk);
      chk("stall_single_xfer", xfer_count, 1);
      chk("stall_after_valid", pool_valid, 0);
      issue_start(0);                 // lands in FETCH
      ready_mode = 0;
      wait_valid();
      issue_start(0);                 // lands in OUT
      ready_mode = 2;
      wait_done(dcyc);
      chk("xfer_count_3", xfer_count, NWIN);
      chk("last_pool_addr_3", last_pool_addr, NWIN - 1);

      // map 4: reset during window 5 fetch, then a clean restart
      for (int i = 0; i < MSIZE; i++) mem[i] = DATA_W'($urandom);
      ready_mode = 1;
      issue_start(1);
      n = 0;
      do begin
         @(posedge clk);
         #2;
         n++;
      end while (!(xfer_count == 5 && rd_en) && n < 200);
      chk("reach_window5_fetch", xfer_count, 5);
      reset = 1'b1;
      exp_q.delete();
      addr_q.delete();
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_idle_outputs("midreset");
      repeat (20) @(negedge clk);
      chk("post_reset_valid", pool_valid, 0);
      chk("post_reset_done", done, 0);
      ready_mode = 2;
      issue_start(1);
      wait_done(dcyc);
      chk("xfer_count_4", xfer_count, NWIN);
      chk("last_pool_addr_4", last_pool_addr, NWIN - 1);
      chk("queue_drained", exp_q.size() + addr_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
